// File: rtl/fir_sample_feeder.sv
// Buffers upstream samples in a small FIFO and presents each one to the filter for TAPS
// enabled cycles. Define FIR_FEEDER_UNDERRUN_EN to enable sticky underrun flag and counter.
module fir_sample_feeder #(
    parameter int TAPS  = 128,
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [17:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [17:0] fir_sig,
    output logic        fir_ready,
    output logic        latch_stb,
    input  logic        clr_underrun,
    output logic        underrun,
    output logic [15:0] underrun_cnt
);
    localparam int DATA_W = 18;
    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = $clog2(TAPS);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] LAST_TAP = CW'(TAPS - 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            tap_q, tap_d;
    logic signed [DATA_W-1:0] sig_q, sig_d;
    logic signed [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [AW:0]              count_q, count_d;
    logic                     s_ready_q;
    logic                     push;
    logic                     pop;
    logic                     fifo_empty;
    logic                     starve;

    assign push       = s_valid && s_ready_q;
    assign fifo_empty = (count_q == '0);

    // Frame sequencing: pop decisions look only at FIFO contents from before this edge.
    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        sig_d   = sig_q;
        pop     = 1'b0;
        starve  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    sig_d   = mem_q[rd_ptr_q];
                    tap_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (tap_q == LAST_TAP) begin
                    tap_d = '0;
                    if (!fifo_empty) begin
                        pop   = 1'b1;
                        sig_d = mem_q[rd_ptr_q];
                    end else begin
                        starve  = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    tap_d = tap_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tap_d   = '0;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Sample storage carries no reset; only the pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= $signed(s_data);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tap_q     <= '0;
            sig_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            s_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tap_q     <= tap_d;
            sig_q     <= sig_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            s_ready_q <= (count_d < FULL_CNT);
        end
    end

    assign s_ready   = s_ready_q;
    assign fir_sig   = sig_q;
    assign fir_ready = (state_q == RUN);
    assign latch_stb = (state_q == RUN) && (tap_q == '0);

`ifdef FIR_FEEDER_UNDERRUN_EN
    logic        underrun_q, underrun_d;
    logic [15:0] ucnt_q, ucnt_d;

    // Clear takes priority over a starvation event in the same cycle.
    always_comb begin
        underrun_d = underrun_q;
        ucnt_d     = ucnt_q;
        if (clr_underrun) begin
            underrun_d = 1'b0;
            ucnt_d     = '0;
        end else if (starve) begin
            underrun_d = 1'b1;
            if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_q <= 1'b0;
            ucnt_q     <= '0;
        end else begin
            underrun_q <= underrun_d;
            ucnt_q     <= ucnt_d;
        end
    end

    assign underrun     = underrun_q;
    assign underrun_cnt = ucnt_q;
`else
    logic unused_underrun_inputs;
    assign unused_underrun_inputs = clr_underrun ^ starve;
    assign underrun     = 1'b0;
    assign underrun_cnt = '0;
`endif

endmodule
